// File: rtl/btn_conditioner.sv
// ---------------------------------------------------------------------------
// btn_conditioner
//   Multi-channel push-button conditioner. Each channel has a 2-flop
//   synchroniser, a counter-based debouncer and a 4-state FSM that produces
//   a stable level plus one-cycle press and release pulses.
//
// Optional feature macro: AUTO_REPEAT_EN
//   When defined, a held button re-pulses btn_press REPEAT_DELAY cycles after
//   the accepted press, then every REPEAT_RATE cycles.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   btn_in       raw active-high button pins (asynchronous to clk)
//   btn_level    debounced stable level per channel
//   btn_press    one-cycle pulse per accepted press (and repeats if enabled)
//   btn_release  one-cycle pulse per accepted release
//   any_press    OR of btn_press, cycle aligned
// ---------------------------------------------------------------------------
module btn_conditioner #(
   parameter int unsigned CHANNELS        = 5,
   parameter int unsigned DEBOUNCE_CYCLES = 500000,
   parameter int unsigned REPEAT_DELAY    = 50000000,
   parameter int unsigned REPEAT_RATE     = 10000000
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [CHANNELS-1:0] btn_in,
   output logic [CHANNELS-1:0] btn_level,
   output logic [CHANNELS-1:0] btn_press,
   output logic [CHANNELS-1:0] btn_release,
   output logic                any_press
);

   localparam int unsigned      CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   // Elaboration-time parameter sanity checks
   if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
      $error("btn_conditioner: DEBOUNCE_CYCLES must be >= 2");
   end
   if (REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_repeat
      $error("btn_conditioner: REPEAT_DELAY and REPEAT_RATE must be >= 1");
   end

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PRESS_WAIT,
      ST_PRESSED,
      ST_RELEASE_WAIT
   } state_t;

   logic [CHANNELS-1:0] r_sync1;
   logic [CHANNELS-1:0] r_sync2;
   state_t              r_state [CHANNELS];
   logic [CNT_W-1:0]    r_cnt   [CHANNELS];
   logic [CHANNELS-1:0] r_level;
   logic [CHANNELS-1:0] r_press;
   logic [CHANNELS-1:0] r_release;
   logic                r_any;

   state_t              w_state_nxt [CHANNELS];
   logic [CNT_W-1:0]    w_cnt_nxt   [CHANNELS];
   logic [CHANNELS-1:0] w_level_nxt;
   logic [CHANNELS-1:0] w_press_nxt;
   logic [CHANNELS-1:0] w_release_nxt;

`ifdef AUTO_REPEAT_EN
   localparam int unsigned      REP_MAX    = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int unsigned      TMR_W      = $clog2(REP_MAX + 1);
   localparam logic [TMR_W-1:0] DELAY_LAST = TMR_W'(REPEAT_DELAY - 1);
   localparam logic [TMR_W-1:0] RATE_LAST  = TMR_W'(REPEAT_RATE - 1);
   localparam logic [TMR_W-1:0] TMR_ONE    = TMR_W'(1);

   // r_rep marks that the first repeat has fired, so the period becomes REPEAT_RATE
   logic [TMR_W-1:0]    r_tmr [CHANNELS];
   logic [CHANNELS-1:0] r_rep;
   logic [TMR_W-1:0]    w_tmr_nxt [CHANNELS];
   logic [CHANNELS-1:0] w_rep_nxt;
`endif

   // Two-flop synchroniser per channel
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= btn_in;
         r_sync2 <= r_sync1;
      end
   end

   // FSM state, counters and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned c = 0; c < CHANNELS; c++) begin
            r_state[c] <= ST_IDLE;
            r_cnt[c]   <= '0;
`ifdef AUTO_REPEAT_EN
            r_tmr[c]   <= '0;
`endif
         end
`ifdef AUTO_REPEAT_EN
         r_rep     <= '0;
`endif
         r_level   <= '0;
         r_press   <= '0;
         r_release <= '0;
         r_any     <= 1'b0;
      end else begin
         for (int unsigned c = 0; c < CHANNELS; c++) begin
            r_state[c] <= w_state_nxt[c];
            r_cnt[c]   <= w_cnt_nxt[c];
`ifdef AUTO_REPEAT_EN
            r_tmr[c]   <= w_tmr_nxt[c];
`endif
         end
`ifdef AUTO_REPEAT_EN
         r_rep     <= w_rep_nxt;
`endif
         r_level   <= w_level_nxt;
         r_press   <= w_press_nxt;
         r_release <= w_release_nxt;
         r_any     <= |w_press_nxt;
      end
   end

   // Next-state and next-output logic, one independent FSM per channel
   always_comb begin
      w_level_nxt   = r_level;
      w_press_nxt   = '0;
      w_release_nxt = '0;
`ifdef AUTO_REPEAT_EN
      w_rep_nxt     = r_rep;
`endif
      for (int unsigned c = 0; c < CHANNELS; c++) begin
         w_state_nxt[c] = r_state[c];
         w_cnt_nxt[c]   = r_cnt[c];
`ifdef AUTO_REPEAT_EN
         w_tmr_nxt[c]   = r_tmr[c];
`endif
         case (r_state[c])
            ST_IDLE: begin
               if (r_sync2[c]) begin
                  w_state_nxt[c] = ST_PRESS_WAIT;
                  w_cnt_nxt[c]   = CNT_ONE;
               end
            end
            ST_PRESS_WAIT: begin
               if (!r_sync2[c]) begin
                  w_state_nxt[c] = ST_IDLE;
                  w_cnt_nxt[c]   = '0;
               end else if (r_cnt[c] == CNT_MAX) begin
                  w_state_nxt[c] = ST_PRESSED;
                  w_cnt_nxt[c]   = '0;
                  w_level_nxt[c] = 1'b1;
                  w_press_nxt[c] = 1'b1;
`ifdef AUTO_REPEAT_EN
                  w_tmr_nxt[c]   = '0;
                  w_rep_nxt[c]   = 1'b0;
`endif
               end else begin
                  w_cnt_nxt[c] = r_cnt[c] + CNT_ONE;
               end
            end
            ST_PRESSED: begin
               if (!r_sync2[c]) begin
                  w_state_nxt[c] = ST_RELEASE_WAIT;
                  w_cnt_nxt[c]   = CNT_ONE;
               end
`ifdef AUTO_REPEAT_EN
               // Repeat timer only advances while the button stays pressed
               else if (r_tmr[c] == (r_rep[c] ? RATE_LAST : DELAY_LAST)) begin
                  w_press_nxt[c] = 1'b1;
                  w_tmr_nxt[c]   = '0;
                  w_rep_nxt[c]   = 1'b1;
               end else begin
                  w_tmr_nxt[c] = r_tmr[c] + TMR_ONE;
               end
`endif
            end
            ST_RELEASE_WAIT: begin
               if (r_sync2[c]) begin
                  w_state_nxt[c] = ST_PRESSED;
                  w_cnt_nxt[c]   = '0;
               end else if (r_cnt[c] == CNT_MAX) begin
                  w_state_nxt[c]   = ST_IDLE;
                  w_cnt_nxt[c]     = '0;
                  w_level_nxt[c]   = 1'b0;
                  w_release_nxt[c] = 1'b1;
`ifdef AUTO_REPEAT_EN
                  w_tmr_nxt[c]     = '0;
                  w_rep_nxt[c]     = 1'b0;
`endif
               end else begin
                  w_cnt_nxt[c] = r_cnt[c] + CNT_ONE;
               end
            end
            default: begin
               w_state_nxt[c] = ST_IDLE;
               w_cnt_nxt[c]   = '0;
            end
         endcase
      end
   end

   assign btn_level   = r_level;
   assign btn_press   = r_press;
   assign btn_release = r_release;
   assign any_press   = r_any;

endmodule

// File: tb/tb_btn_conditioner.sv
// ---------------------------------------------------------------------------
// tb_btn_conditioner
//   Randomised and directed stimulus for btn_conditioner, checked every cycle
//   against a reference model: a button level flips once the synchronised
//   input has disagreed with it for DEBOUNCE_CYCLES+1 consecutive samples.
//   Repeat pulses are predicted from the number of held cycles since the
//   accepted press.
// ---------------------------------------------------------------------------
module tb_btn_conditioner;

   localparam int unsigned CH = 5;
   localparam int unsigned DB = 4;
   localparam int unsigned RD = 10;
   localparam int unsigned RR = 3;

   logic          clk = 1'b0;
   logic          rst;
   logic [CH-1:0] btn_in;
   logic [CH-1:0] btn_level;
   logic [CH-1:0] btn_press;
   logic [CH-1:0] btn_release;
   logic          any_press;

   always #5 clk = ~clk;

   btn_conditioner #(
      .CHANNELS        (CH),
      .DEBOUNCE_CYCLES (DB),
      .REPEAT_DELAY    (RD),
      .REPEAT_RATE     (RR)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .btn_in      (btn_in),
      .btn_level   (btn_level),
      .btn_press   (btn_press),
      .btn_release (btn_release),
      .any_press   (any_press)
   );

   // Reference model state
   logic [CH-1:0] m_s1, m_s2, m_level, m_press, m_release;
   int            m_run  [CH];
   int            m_held [CH];
   int            n_vec = 0;
   int            n_err = 0;

   logic [3*CH:0] got, exp_v;

   // Advance one clock edge and update the model with the inputs seen at it
   task automatic tick();
      logic sv;
      @(posedge clk);
      if (rst) begin
         m_s1 = '0; m_s2 = '0; m_level = '0; m_press = '0; m_release = '0;
         for (int c = 0; c < CH; c++) begin
            m_run[c]  = 0;
            m_held[c] = 0;
         end
      end else begin
         for (int c = 0; c < CH; c++) begin
            sv           = m_s2[c];
            m_press[c]   = 1'b0;
            m_release[c] = 1'b0;
`ifdef AUTO_REPEAT_EN
            if (m_level[c] && m_run[c] == 0 && sv) begin
               m_held[c]++;
               if (m_held[c] == int'(RD) ||
                   (m_held[c] > int'(RD) && (m_held[c] - int'(RD)) % int'(RR) == 0))
                  m_press[c] = 1'b1;
            end
`endif
            if (sv != m_level[c]) begin
               m_run[c]++;
               if (m_run[c] == int'(DB) + 1) begin
                  m_level[c] = sv;
                  if (sv) m_press[c] = 1'b1;
                  else    m_release[c] = 1'b1;
                  m_run[c]  = 0;
                  m_held[c] = 0;
               end
            end else begin
               m_run[c] = 0;
            end
         end
         m_s2 = m_s1;
         m_s1 = btn_in;
      end
      #1;
      got   = {btn_level, btn_press, btn_release, any_press};
      exp_v = {m_level, m_press, m_release, |m_press};
   endtask

   task automatic do_reset();
      rst    = 1'b1;
      btn_in = '0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst    = 1'b1;
      btn_in = 5'b10110;
      for (int t = 0; t < 4; t++) begin
         tick();
         n_vec++;
         if (got !== '0) begin
            n_err++;
            $display("FAIL reset cyc %0d got %h required 0", t, got);
         end
      end
      btn_in = '0;
      rst    = 1'b0;
   endtask

   task automatic test_latency();
      btn_in[0] = 1'b1;
      for (int t = 0; t < 12; t++) begin
         tick();
         n_vec++;
         if (got !== exp_v) begin
            n_err++;
            $display("FAIL latency_model cyc %0d got %h required %h", t, got, exp_v);
         end
         n_vec++;
         if (btn_press[0] !== (t == int'(DB) + 2) || any_press !== (t == int'(DB) + 2) ||
             btn_level[0] !== (t >= int'(DB) + 2)) begin
            n_err++;
            $display("FAIL latency cyc %0d press %b any %b level %b", t, btn_press[0], any_press, btn_level[0]);
         end
      end
   endtask

   task automatic test_release();
      btn_in[0] = 1'b0;
      for (int t = 0; t < 12; t++) begin
         tick();
         n_vec++;
         if (got !== exp_v) begin
            n_err++;
            $display("FAIL release_model cyc %0d got %h required %h", t, got, exp_v);
         end
         n_vec++;
         if (btn_release[0] !== (t == int'(DB) + 2) || btn_press[0] !== 1'b0 ||
             btn_level[0] !== (t < int'(DB) + 2)) begin
            n_err++;
            $display("FAIL release cyc %0d rel %b press %b level %b", t, btn_release[0], btn_press[0], btn_level[0]);
         end
      end
   endtask

   task automatic test_bounce();
      for (int t = 0; t < 52; t++) begin
         if (t < 40 && t % 2 == 0) btn_in[1] = ~btn_in[1];
         if (t == 40) btn_in[1] = 1'b0;
         tick();
         n_vec++;
         if (got !== exp_v || btn_level[1] !== 1'b0 || btn_press[1] !== 1'b0 || btn_release[1] !== 1'b0) begin
            n_err++;
            $display("FAIL bounce cyc %0d got %h required %h", t, got, exp_v);
         end
      end
   endtask

   task automatic test_simultaneous();
      int hits;
      hits = 0;
      btn_in[2] = 1'b1;
      btn_in[4] = 1'b1;
      for (int t = 0; t < 12; t++) begin
         tick();
         n_vec++;
         if (got !== exp_v) begin
            n_err++;
            $display("FAIL simul_model cyc %0d got %h required %h", t, got, exp_v);
         end
         if (btn_press === 5'b10100 && any_press === 1'b1) hits++;
      end
      n_vec++;
      if (hits != 1) begin
         n_err++;
         $display("FAIL simul_pulse count %0d required 1", hits);
      end
      btn_in = '0;
      for (int t = 0; t < 12; t++) tick();
   endtask

   task automatic test_reset_mid();
      do_reset();
      btn_in[3] = 1'b1;
      tick();
      tick();
      rst = 1'b1;
      tick();
      n_vec++;
      if (got !== '0) begin
         n_err++;
         $display("FAIL reset_mid_hold got %h required 0", got);
      end
      rst = 1'b0;
      for (int t = 0; t < 12; t++) begin
         tick();
         n_vec++;
         if (got !== exp_v || btn_press[3] !== (t == int'(DB) + 2)) begin
            n_err++;
            $display("FAIL reset_mid cyc %0d got %h required %h", t, got, exp_v);
         end
      end
   endtask

   task automatic test_random();
      int hold [CH];
      do_reset();
      for (int c = 0; c < CH; c++) hold[c] = 1;
      for (int t = 0; t < 1500; t++) begin
         for (int c = 0; c < CH; c++) begin
            hold[c]--;
            if (hold[c] <= 0) begin
               btn_in[c] = ~btn_in[c];
               hold[c]   = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4))
                                                       : int'($urandom_range(5, 24));
            end
         end
         rst = ($urandom_range(0, 299) == 0);
         tick();
         n_vec++;
         if (got !== exp_v) begin
            n_err++;
            $display("FAIL random cyc %0d got %h required %h", t, got, exp_v);
         end
         rst = 1'b0;
      end
   endtask

   task automatic test_repeat();
      int offs [$];
      int want [$];
      bit found;
`ifdef AUTO_REPEAT_EN
      want = '{10, 13, 16, 19, 22};
`endif
      do_reset();
      found     = 1'b0;
      btn_in[0] = 1'b1;
      for (int t = 0; t < 20 && !found; t++) begin
         tick();
         if (btn_press[0] === 1'b1) found = 1'b1;
      end
      n_vec++;
      if (!found) begin
         n_err++;
         $display("FAIL repeat_accept timeout got 0 required 1");
      end
      for (int k = 1; k <= 40; k++) begin
         if (k == 23) btn_in[0] = 1'b0;
         tick();
         n_vec++;
         if (got !== exp_v) begin
            n_err++;
            $display("FAIL repeat_model off %0d got %h required %h", k, got, exp_v);
         end
         if (btn_press[0] === 1'b1) offs.push_back(k);
      end
      n_vec++;
      if (offs.size() != want.size()) begin
         n_err++;
         $display("FAIL repeat_count got %0d required %0d", offs.size(), want.size());
      end else begin
         for (int i = 0; i < want.size(); i++) begin
            n_vec++;
            if (offs[i] != want[i]) begin
               n_err++;
               $display("FAIL repeat_offset %0d got %0d required %0d", i, offs[i], want[i]);
            end
         end
      end
   endtask

   initial begin
      rst    = 1'b1;
      btn_in = '0;
      test_reset();
      do_reset();
      test_latency();
      test_release();
      test_bounce();
      test_simultaneous();
      test_reset_mid();
      test_repeat();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
